// File: rtl/vend_pkg.sv
// vend_pkg: shared state encodings, prices and packed-stock helpers for the vending purchase path
package vend_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BROWSE = 3'd1,
        PAY    = 3'd2,
        DONE   = 3'd3,
        REFUND = 3'd4
    } state_t;

    localparam int NUM_GOODS = 7;
    localparam int SLOT_W    = 3;
    localparam int STOCK_W   = NUM_GOODS * SLOT_W;

    localparam logic [4:0] PRICE1 = 5'd2;
    localparam logic [4:0] PRICE2 = 5'd3;
    localparam logic [4:0] PRICE3 = 5'd3;
    localparam logic [4:0] PRICE4 = 5'd4;
    localparam logic [4:0] PRICE5 = 5'd5;
    localparam logic [4:0] PRICE6 = 5'd5;
    localparam logic [4:0] PRICE7 = 5'd7;

    // item k (1..NUM_GOODS) lives at bits [SLOT_W*k-1 : SLOT_W*k-SLOT_W]
    function automatic logic [SLOT_W-1:0] get_slot(input logic [STOCK_W-1:0] s, input logic [2:0] idx);
        get_slot = '0;
        for (int k = 1; k <= NUM_GOODS; k++)
            if (idx == 3'(k)) get_slot = s[SLOT_W*k-SLOT_W +: SLOT_W];
    endfunction

    function automatic logic [STOCK_W-1:0] put_slot(input logic [STOCK_W-1:0] s, input logic [2:0] idx,
                                                   input logic [SLOT_W-1:0] v);
        put_slot = s;
        for (int k = 1; k <= NUM_GOODS; k++)
            if (idx == 3'(k)) put_slot[SLOT_W*k-SLOT_W +: SLOT_W] = v;
    endfunction

    // unselected index returns the maximum price so it can never be satisfied
    function automatic logic [4:0] price(input logic [2:0] idx);
        price = idx == 3'd1 ? PRICE1 :
                idx == 3'd2 ? PRICE2 :
                idx == 3'd3 ? PRICE3 :
                idx == 3'd4 ? PRICE4 :
                idx == 3'd5 ? PRICE5 :
                idx == 3'd6 ? PRICE6 :
                idx == 3'd7 ? PRICE7 : 5'd31;
    endfunction

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [2:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {3'b000, b};
        sat_add = sum[5] ? 5'd31 : sum[4:0];
    endfunction
endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: two-flop synchronizer, stable-high debounce and single press pulse per button hold
module btn_pulse #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_pulse
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_pulse;

    // counter saturates at DEB_MAX so a held button fires once; a low sample re-arms it
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_raw;
            r_sync  <= r_meta;
            r_cnt   <= !r_sync ? '0 : (r_cnt == DEB_MAX ? r_cnt : r_cnt + 1'b1);
            r_pulse <= r_sync && r_cnt == DEB_LAST;
        end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/customer_purchase.sv
// customer_purchase: browse/pay/dispense controller owning stock, selection, credit and change
module customer_purchase
    import vend_pkg::*;
#(
    parameter logic [2:0] INIT_STOCK  = 3'd5,
    parameter int         DEB_CYCLES  = 500000,
    parameter int         HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        EN,
    input  logic        btn_next,
    input  logic        btn_confirm,
    input  logic        btn_cancel,
    input  logic        coin_valid,
    input  logic [2:0]  coin_val,
    input  logic        restock,
    input  logic [20:0] restock_data,
    output logic [20:0] goodleft,
    output logic [2:0]  behavior,
    output logic [4:0]  paid,
    output logic [4:0]  change,
    output logic        dispense,
    output logic        sold_out,
    output logic [2:0]  state
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              w_next;
    logic              w_confirm;
    logic              w_cancel;
    logic [SLOT_W-1:0] w_slot;
    logic [4:0]        w_price;
    logic [2:0]        w_coin;

    state_t             r_state;
    logic [STOCK_W-1:0] r_stock;
    logic [2:0]         r_behavior;
    logic [4:0]         r_paid;
    logic [4:0]         r_change;
    logic               r_dispense;
    logic               r_sold_out;
    logic [HOLD_W-1:0]  r_hold;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_next    (.clk(clk), .i_rst_n(EN), .i_raw(btn_next),    .o_pulse(w_next));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_confirm (.clk(clk), .i_rst_n(EN), .i_raw(btn_confirm), .o_pulse(w_confirm));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_cancel  (.clk(clk), .i_rst_n(EN), .i_raw(btn_cancel),  .o_pulse(w_cancel));

    assign w_slot  = get_slot(r_stock, r_behavior);
    assign w_price = price(r_behavior);
    assign w_coin  = coin_valid ? coin_val : 3'd0;

    always_ff @(posedge clk or negedge EN)
        if (!EN) begin
            r_state    <= IDLE;
            r_stock    <= {NUM_GOODS{INIT_STOCK}};
            r_behavior <= 3'd0;
            r_paid     <= 5'd0;
            r_change   <= 5'd0;
            r_dispense <= 1'b0;
            r_sold_out <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_dispense <= 1'b0;
            r_sold_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (restock) r_stock <= restock_data;
                    if (w_next) begin
                        r_state    <= BROWSE;
                        r_behavior <= 3'd1;
                    end
                end
                BROWSE:
                    if (w_cancel) begin
                        r_state    <= IDLE;
                        r_behavior <= 3'd0;
                    end else if (w_confirm) begin
                        if (w_slot != '0) begin
                            r_state <= PAY;
                            r_paid  <= 5'd0;
                        end else
                            r_sold_out <= 1'b1;
                    end else if (w_next)
                        r_behavior <= r_behavior == 3'd7 ? 3'd1 : r_behavior + 3'd1;
                // cancel outranks a satisfied price; a coin in the cancel cycle is refunded too
                PAY:
                    if (w_cancel) begin
                        r_state  <= REFUND;
                        r_change <= sat_add(r_paid, w_coin);
                        r_paid   <= 5'd0;
                    end else if (r_paid >= w_price) begin
                        r_state    <= DONE;
                        r_stock    <= put_slot(r_stock, r_behavior, w_slot - 3'd1);
                        r_change   <= r_paid - w_price;
                        r_paid     <= 5'd0;
                        r_dispense <= 1'b1;
                    end else if (coin_valid)
                        r_paid <= sat_add(r_paid, coin_val);
                DONE, REFUND:
                    if (r_hold == HOLD_LAST) begin
                        r_state    <= IDLE;
                        r_hold     <= '0;
                        r_change   <= 5'd0;
                        r_behavior <= 3'd0;
                    end else
                        r_hold <= r_hold + 1'b1;
                default: r_state <= IDLE;
            endcase
        end

    assign goodleft = r_stock;
    assign behavior = r_behavior;
    assign paid     = r_paid;
    assign change   = r_change;
    assign dispense = r_dispense;
    assign sold_out = r_sold_out;
    assign state    = r_state;
endmodule

// File: tb/tb_customer_purchase.sv
// tb_customer_purchase: scenario tasks plus a dispense/sold-out scoreboard for customer_purchase
module tb_customer_purchase;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        EN = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_confirm = 1'b0;
    logic        btn_cancel = 1'b0;
    logic        coin_valid = 1'b0;
    logic [2:0]  coin_val = 3'd0;
    logic        restock = 1'b0;
    logic [20:0] restock_data = 21'd0;
    logic [20:0] goodleft;
    logic [2:0]  behavior;
    logic [4:0]  paid;
    logic [4:0]  change;
    logic        dispense;
    logic        sold_out;
    logic [2:0]  state;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  chg;
        logic [20:0] stk;
    } disp_t;
    disp_t       sb_disp[$];
    logic [2:0]  sb_sold[$];
    logic [20:0] exp_stock;

    customer_purchase #(.INIT_STOCK(3'd5), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .EN(EN), .btn_next(btn_next), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
        .coin_valid(coin_valid), .coin_val(coin_val), .restock(restock), .restock_data(restock_data),
        .goodleft(goodleft), .behavior(behavior), .paid(paid), .change(change),
        .dispense(dispense), .sold_out(sold_out), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] dec_slot(input logic [20:0] s, input int k);
        logic [20:0] r;
        r = s;
        r[3*k-3 +: 3] = r[3*k-3 +: 3] - 3'd1;
        return r;
    endfunction

    always @(negedge clk) if (EN) begin
        if (dispense) begin
            n_total++;
            if (sb_disp.size() == 0)
                $display("FAIL dispense_unexpected change=%0d goodleft=%o", change, goodleft);
            else begin
                disp_t e;
                e = sb_disp.pop_front();
                if (change !== e.chg || goodleft !== e.stk || state !== 3'd3)
                    $display("FAIL dispense got change=%0d goodleft=%o state=%0d want change=%0d goodleft=%o state=3",
                             change, goodleft, state, e.chg, e.stk);
                else n_pass++;
            end
        end
        if (sold_out) begin
            n_total++;
            if (sb_sold.size() == 0)
                $display("FAIL sold_out_unexpected behavior=%0d", behavior);
            else begin
                logic [2:0] eb;
                eb = sb_sold.pop_front();
                if (behavior !== eb || state !== 3'd1 || goodleft !== exp_stock)
                    $display("FAIL sold_out got behavior=%0d state=%0d goodleft=%o want behavior=%0d state=1 goodleft=%o",
                             behavior, state, goodleft, eb, exp_stock);
                else n_pass++;
            end
        end
    end

    task automatic press(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_next = (b == 0);
            btn_confirm = (b == 1);
            btn_cancel = (b == 2);
            repeat (DEB + 4) @(negedge clk);
            btn_next = 1'b0;
            btn_confirm = 1'b0;
            btn_cancel = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic coin(input logic [2:0] v);
        @(negedge clk);
        coin_valid = 1'b1;
        coin_val = v;
        @(negedge clk);
        coin_valid = 1'b0;
        coin_val = 3'd0;
    endtask

    task automatic do_restock(input logic [20:0] d);
        @(negedge clk);
        restock = 1'b1;
        restock_data = d;
        @(negedge clk);
        restock = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3 * HOLD && state !== 3'd0; k++) @(negedge clk);
        n_total++;
        if (state !== 3'd0) $display("FAIL %s_idle_timeout state=%0d want 0", name, state);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if (goodleft !== 21'o5555555 || behavior !== 3'd0 || state !== 3'd0 || paid !== 5'd0 ||
            change !== 5'd0 || dispense !== 1'b0 || sold_out !== 1'b0)
            $display("FAIL reset goodleft=%o behavior=%0d state=%0d paid=%0d change=%0d disp=%b so=%b want 5555555/0/0/0/0/0/0",
                     goodleft, behavior, state, paid, change, dispense, sold_out);
        else n_pass++;
        EN = 1'b1;
        exp_stock = 21'o5555555;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_browse_wrap();
        for (int i = 0; i < 9; i++) begin
            press(0, 1);
            n_total++;
            if (behavior !== 3'((i % 7) + 1) || state !== 3'd1)
                $display("FAIL browse_next%0d behavior=%0d state=%0d want %0d/1", i, behavior, state, (i % 7) + 1);
            else n_pass++;
        end
        press(2, 1);
        n_total++;
        if (behavior !== 3'd0 || state !== 3'd0)
            $display("FAIL browse_cancel behavior=%0d state=%0d want 0/0", behavior, state);
        else n_pass++;
    endtask

    task automatic test_purchase();
        press(0, 4);
        press(1, 1);
        n_total++;
        if (behavior !== 3'd4 || state !== 3'd2 || paid !== 5'd0)
            $display("FAIL buy_select behavior=%0d state=%0d paid=%0d want 4/2/0", behavior, state, paid);
        else n_pass++;
        coin(3'd1);
        n_total++;
        if (paid !== 5'd1) $display("FAIL buy_coin1 paid=%0d want 1", paid); else n_pass++;
        coin(3'd1);
        n_total++;
        if (paid !== 5'd2) $display("FAIL buy_coin2 paid=%0d want 2", paid); else n_pass++;
        sb_disp.push_back('{chg: 5'd3, stk: dec_slot(exp_stock, 4)});
        exp_stock = dec_slot(exp_stock, 4);
        coin(3'd5);
        n_total++;
        if (paid !== 5'd7 || state !== 3'd2) $display("FAIL buy_coin3 paid=%0d state=%0d want 7/2", paid, state);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (state !== 3'd3 || paid !== 5'd0 || change !== 5'd3)
            $display("FAIL buy_done state=%0d paid=%0d change=%0d want 3/0/3", state, paid, change);
        else n_pass++;
        repeat (HOLD - 1) @(negedge clk);
        n_total++;
        if (state !== 3'd3 || change !== 5'd3 || dispense !== 1'b0)
            $display("FAIL buy_hold state=%0d change=%0d disp=%b want 3/3/0", state, change, dispense);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (state !== 3'd0 || change !== 5'd0 || behavior !== 3'd0 || goodleft !== exp_stock)
            $display("FAIL buy_release state=%0d change=%0d behavior=%0d goodleft=%o want 0/0/0/%o",
                     state, change, behavior, goodleft, exp_stock);
        else n_pass++;
    endtask

    task automatic test_restock();
        do_restock(21'o1234567);
        exp_stock = 21'o1234567;
        n_total++;
        if (goodleft !== exp_stock) $display("FAIL restock_idle goodleft=%o want %o", goodleft, exp_stock);
        else n_pass++;
    endtask

    task automatic test_sold_out();
        do_restock(21'o1234067);
        exp_stock = 21'o1234067;
        press(0, 3);
        do_restock(21'o7777777);
        n_total++;
        if (goodleft !== exp_stock || behavior !== 3'd3)
            $display("FAIL restock_browse goodleft=%o behavior=%0d want %o/3", goodleft, behavior, exp_stock);
        else n_pass++;
        sb_sold.push_back(3'd3);
        press(1, 1);
        n_total++;
        if (state !== 3'd1 || goodleft !== exp_stock)
            $display("FAIL sold_out_stay state=%0d goodleft=%o want 1/%o", state, goodleft, exp_stock);
        else n_pass++;
        press(2, 1);
    endtask

    task automatic test_refund();
        press(0, 7);
        press(1, 1);
        coin(3'd3);
        n_total++;
        if (behavior !== 3'd7 || state !== 3'd2 || paid !== 5'd3)
            $display("FAIL refund_pay behavior=%0d state=%0d paid=%0d want 7/2/3", behavior, state, paid);
        else n_pass++;
        // the cancel pulse reaches the FSM DEB+2 edges after the raw rise; land the coin on that edge
        @(negedge clk);
        btn_cancel = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        coin_valid = 1'b1;
        coin_val = 3'd2;
        @(negedge clk);
        coin_valid = 1'b0;
        coin_val = 3'd0;
        n_total++;
        if (state !== 3'd4 || change !== 5'd5 || paid !== 5'd0)
            $display("FAIL refund_cancel state=%0d change=%0d paid=%0d want 4/5/0", state, change, paid);
        else n_pass++;
        btn_cancel = 1'b0;
        coin(3'd4);
        n_total++;
        if (state !== 3'd4 || change !== 5'd5 || paid !== 5'd0)
            $display("FAIL refund_coin_ignored state=%0d change=%0d paid=%0d want 4/5/0", state, change, paid);
        else n_pass++;
        wait_idle("refund");
        n_total++;
        if (goodleft !== exp_stock || change !== 5'd0)
            $display("FAIL refund_stock goodleft=%o change=%0d want %o/0", goodleft, change, exp_stock);
        else n_pass++;
    endtask

    task automatic test_saturation();
        press(0, 7);
        press(1, 1);
        sb_disp.push_back('{chg: 5'd0, stk: dec_slot(exp_stock, 7)});
        exp_stock = dec_slot(exp_stock, 7);
        coin(3'd7);
        n_total++;
        if (paid !== 5'd7 || state !== 3'd2) $display("FAIL sat_first paid=%0d state=%0d want 7/2", paid, state);
        else n_pass++;
        for (int i = 0; i < 4; i++) coin(3'd7);
        n_total++;
        if (state !== 3'd3 || paid !== 5'd0 || change !== 5'd0)
            $display("FAIL sat_done state=%0d paid=%0d change=%0d want 3/0/0", state, paid, change);
        else n_pass++;
        wait_idle("sat");
    endtask

    task automatic test_async_reset();
        do_restock(21'o7777777);
        exp_stock = 21'o7777777;
        press(0, 7);
        press(1, 1);
        coin(3'd3);
        coin(3'd3);
        n_total++;
        if (paid !== 5'd6 || state !== 3'd2) $display("FAIL arst_setup paid=%0d state=%0d want 6/2", paid, state);
        else n_pass++;
        #3 EN = 1'b0;
        #1;
        n_total++;
        if (goodleft !== 21'o5555555 || behavior !== 3'd0 || state !== 3'd0 || paid !== 5'd0 ||
            change !== 5'd0 || dispense !== 1'b0 || sold_out !== 1'b0)
            $display("FAIL arst goodleft=%o behavior=%0d state=%0d paid=%0d change=%0d want 5555555/0/0/0/0",
                     goodleft, behavior, state, paid, change);
        else n_pass++;
        @(negedge clk);
        EN = 1'b1;
        exp_stock = 21'o5555555;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_browse_wrap();
        test_purchase();
        test_restock();
        test_sold_out();
        test_refund();
        test_saturation();
        test_async_reset();
        n_total++;
        if (sb_disp.size() != 0 || sb_sold.size() != 0)
            $display("FAIL scoreboard_drain dispense_left=%0d sold_out_left=%0d want 0/0", sb_disp.size(), sb_sold.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
